// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and status flags.
package alu_seq_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial-product step per i_step cycle.
// The multiplier occupies the low half of the product register and is consumed
// from the LSB while the accumulator grows in the high half.
module alu_seq_mul #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic           i_step,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_product_c
);

    logic [W-1:0]   r_mcand;
    logic [2*W-1:0] r_prod;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_prod_step;

    // Add the multiplicand into the high half when the current multiplier bit is set, then shift right.
    always_comb begin
        w_sum       = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_mcand} : (W+1)'(0));
        w_prod_step = {w_sum, r_prod[W-1:1]};
    end

    // Product value after this cycle's step, so the final product is usable on the last step edge.
    assign o_product_c = i_step ? w_prod_step : r_prod;

    // Operand capture on load, one iteration per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_prod  <= '0;
        end else if (i_load) begin
            r_mcand <= i_a;
            r_prod  <= {W'(0), i_b};
        end else if (i_step) begin
            r_prod  <= w_prod_step;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift ops and a W-cycle multiply
// behind a start/busy/done handshake; result and flags hold until the next completion.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [OP_W-1:0] op,
    output logic [W-1:0]    result,
    output logic            n_flag,
    output logic            z_flag,
    output logic            c_flag,
    output logic            v_flag,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CW = $clog2(W) + 1;

    alu_state_e     r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [W-1:0]   r_result, w_result_nxt;
    alu_flags_t     r_flags, w_flags_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;

    alu_op_e        w_op;
    logic [W:0]     w_add;
    logic [W:0]     w_sub;
    logic [W:0]     w_shl;
    logic [W:0]     w_shr;
    logic           w_shamt_ok;
    logic [W-1:0]   w_alu_res;
    logic           w_alu_c;
    logic           w_alu_v;
    alu_flags_t     w_alu_flags;

    logic           w_mul_load;
    logic           w_mul_step;
    logic [2*W-1:0] w_product;
    logic           w_mul_hi_nz;

    assign w_op = alu_op_e'(op);

    // Extended-width arithmetic: the extra MSB carries the carry/borrow and the last bit shifted out.
    assign w_add      = {1'b0, a} + {1'b0, b};
    assign w_sub      = {1'b0, a} - {1'b0, b};
    assign w_shl      = {1'b0, a} << b;
    assign w_shr      = {a, 1'b0} >> b;
    assign w_shamt_ok = (b != '0) && (b < W'(W));

    // Single-cycle datapath: result plus carry/overflow for every non-multiply opcode.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_alu_res = w_add[W-1:0];
                w_alu_c   = w_add[W];
                w_alu_v   = (a[W-1] == b[W-1]) && (w_add[W-1] != a[W-1]);
            end
            OP_SUB: begin
                w_alu_res = w_sub[W-1:0];
                w_alu_c   = ~w_sub[W];
                w_alu_v   = (a[W-1] ^ b[W-1]) & (a[W-1] ^ w_sub[W-1]);
            end
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_XOR: w_alu_res = a ^ b;
            OP_SHL: begin
                if (b == '0) begin
                    w_alu_res = a;
                end else if (w_shamt_ok) begin
                    w_alu_res = w_shl[W-1:0];
                    w_alu_c   = w_shl[W];
                end
            end
            OP_SHR: begin
                if (b == '0) begin
                    w_alu_res = a;
                end else if (w_shamt_ok) begin
                    w_alu_res = w_shr[W:1];
                    w_alu_c   = w_shr[0];
                end
            end
            default: begin
                w_alu_res = '0;
            end
        endcase
    end

    assign w_alu_flags = '{n: w_alu_res[W-1], z: (w_alu_res == '0), c: w_alu_c, v: w_alu_v};
    assign w_mul_hi_nz = |w_product[2*W-1:W];

    alu_seq_mul #(
        .W (W)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_mul_load),
        .i_step      (w_mul_step),
        .i_a         (a),
        .i_b         (b),
        .o_product_c (w_product)
    );

    // Next-state and output decode: accept starts in IDLE, run W multiply iterations in MUL.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_mul_load   = 1'b0;
        w_mul_step   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_op == OP_MUL) begin
                        w_mul_load  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = MUL;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_result_nxt = w_alu_res;
                        w_flags_nxt  = w_alu_flags;
                        w_done_nxt   = 1'b1;
                    end
                end
            end
            MUL: begin
                w_mul_step = 1'b1;
                w_cnt_nxt  = r_cnt + CW'(1);
                if (r_cnt == CW'(W - 1)) begin
                    w_state_nxt  = IDLE;
                    w_result_nxt = w_product[W-1:0];
                    w_flags_nxt  = '{n: w_product[W-1], z: (w_product[W-1:0] == '0),
                                     c: w_mul_hi_nz, v: w_mul_hi_nz};
                    w_done_nxt   = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_flags  <= w_flags_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign result = r_result;
    assign n_flag = r_flags.n;
    assign z_flag = r_flags.z;
    assign c_flag = r_flags.c;
    assign v_flag = r_flags.v;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8): directed cases plus random ops against an arithmetic model.
module tb_alu_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] result;
    logic         n_flag, z_flag, c_flag, v_flag;
    logic         busy, done;

    int           n_checks = 0;
    int           n_err    = 0;
    logic [11:0]  exp_hold;

    alu_seq #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result),
        .n_flag (n_flag),
        .z_flag (z_flag),
        .c_flag (c_flag),
        .v_flag (v_flag),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // {result, n, z, c, v} from the opcode rules, using plain integer arithmetic.
    function automatic logic [11:0] model(input int o, input int x, input int y);
        int r, s, sx, sy;
        logic c, v, n, z;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        case (o)
            0: begin r = x + y; c = (r > 255); s = sx + sy; v = (s > 127) || (s < -128); end
            1: begin r = x - y; c = (x >= y);  s = sx - sy; v = (s > 127) || (s < -128); end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin
                if (y == 0) r = x;
                else if (y < 8) begin r = x << y; c = ((x >> (8 - y)) & 1) != 0; end
                else r = 0;
            end
            6: begin
                if (y == 0) r = x;
                else if (y < 8) begin r = x >> y; c = ((x >> (y - 1)) & 1) != 0; end
                else r = 0;
            end
            default: begin r = x * y; c = (r > 255); v = c; end
        endcase
        r = r & 255;
        n = (r >= 128);
        z = (r == 0);
        return {8'(r), n, z, c, v};
    endfunction

    function automatic logic [11:0] obs();
        return {result, n_flag, z_flag, c_flag, v_flag};
    endfunction

    // One handshake: idle check, start, then busy/done timing and the final value.
    task automatic run_op(input int o, input int x, input int y, input int inject_at,
                          input bit noisy, input string tag);
        logic [11:0] e;
        e = model(o, x, y);
        @(negedge clk);
        check({tag, " idle_done"}, 32'(done), 32'(0));
        check({tag, " idle_hold"}, 32'(obs()), 32'(exp_hold));
        start = 1'b1;
        op    = 3'(o);
        a     = 8'(x);
        b     = 8'(y);
        if (o != 7) begin
            @(negedge clk);
            check({tag, " done"}, 32'(done), 32'(1));
            check({tag, " busy"}, 32'(busy), 32'(0));
            check({tag, " value"}, 32'(obs()), 32'(e));
            start = 1'b0;
        end else begin
            for (int i = 1; i <= int'(W); i++) begin
                @(negedge clk);
                check({tag, " mul_busy"}, 32'(busy), 32'(1));
                check({tag, " mul_nodone"}, 32'(done), 32'(0));
                check({tag, " mul_hold"}, 32'(obs()), 32'(exp_hold));
                a     = 8'($urandom);
                b     = 8'($urandom);
                op    = 3'($urandom);
                start = noisy ? 1'($urandom) : 1'b0;
                if (i == inject_at) begin
                    start = 1'b1;
                    op    = 3'd0;
                    a     = 8'd1;
                    b     = 8'd1;
                end
            end
            @(negedge clk);
            check({tag, " mul_done"}, 32'(done), 32'(1));
            check({tag, " mul_busy_off"}, 32'(busy), 32'(0));
            check({tag, " mul_value"}, 32'(obs()), 32'(e));
            start = 1'b0;
        end
        exp_hold = e;
    endtask

    initial begin
        logic [11:0] e_prev;
        int          o, x, y;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = '0;
        exp_hold = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset value", 32'(obs()), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset done", 32'(done), 32'(0));
        rst = 1'b0;

        // Directed single-cycle cases.
        run_op(0, 8'h7F, 8'h01, 0, 1'b0, "add_7f_01");
        check("add_7f_01 exact", 32'(obs()), 32'({8'h80, 4'b1001}));
        run_op(1, 8'h05, 8'h05, 0, 1'b0, "sub_5_5");
        check("sub_5_5 exact", 32'(obs()), 32'({8'h00, 4'b0110}));
        run_op(1, 8'h03, 8'h05, 0, 1'b0, "sub_3_5");
        check("sub_3_5 exact", 32'(obs()), 32'({8'hFE, 4'b1000}));
        run_op(5, 8'h81, 8'h01, 0, 1'b0, "shl_81_1");
        check("shl_81_1 exact", 32'(obs()), 32'({8'h02, 4'b0010}));
        run_op(6, 8'h81, 8'h08, 0, 1'b0, "shr_81_8");
        check("shr_81_8 exact", 32'(obs()), 32'({8'h00, 4'b0100}));
        run_op(5, 8'hA5, 8'h00, 0, 1'b0, "shl_by0");
        run_op(6, 8'hA5, 8'h07, 0, 1'b0, "shr_by7");
        run_op(2, 8'hF0, 8'h3C, 0, 1'b0, "and");
        run_op(3, 8'hF0, 8'h0C, 0, 1'b0, "or");
        run_op(4, 8'hFF, 8'hFF, 0, 1'b0, "xor");

        // Directed multiplies, including a start injected while busy.
        run_op(7, 15, 17, 0, 1'b0, "mul_15_17");
        check("mul_15_17 exact", 32'(obs()), 32'({8'hFF, 4'b1000}));
        run_op(7, 16, 16, 0, 1'b0, "mul_16_16");
        check("mul_16_16 exact", 32'(obs()), 32'({8'h00, 4'b0111}));
        run_op(7, 15, 17, 3, 1'b0, "mul_inject");
        @(negedge clk);
        check("mul_inject after_done", 32'(done), 32'(0));
        check("mul_inject after_hold", 32'(obs()), 32'(exp_hold));

        // Reset in the middle of a multiply aborts it; the next start is accepted at once.
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = 8'd200; b = 8'd3;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("abort busy", 32'(busy), 32'(1));
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort value", 32'(obs()), 32'(0));
        check("abort busy_off", 32'(busy), 32'(0));
        check("abort no_done", 32'(done), 32'(0));
        rst = 1'b0;
        start = 1'b1; op = 3'd0; a = 8'd2; b = 8'd3;
        @(negedge clk);
        check("post_reset add done", 32'(done), 32'(1));
        check("post_reset add value", 32'(obs()), 32'({8'h05, 4'b0000}));
        start = 1'b0;
        exp_hold = {8'h05, 4'b0000};

        // Back-to-back single-cycle ops, one per cycle.
        e_prev = '0;
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("b2b done", 32'(done), 32'(1));
                check("b2b value", 32'(obs()), 32'(e_prev));
            end
            if (i < 30) begin
                o = int'($urandom_range(0, 6));
                x = int'($urandom_range(0, 255));
                y = (o >= 5) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255));
                e_prev = model(o, x, y);
                start = 1'b1; op = 3'(o); a = 8'(x); b = 8'(y);
            end else begin
                start = 1'b0;
                exp_hold = e_prev;
            end
        end

        // Random mix of all opcodes; inputs and spurious starts churn while busy.
        for (int i = 0; i < 150; i++) begin
            o = int'($urandom_range(0, 7));
            x = int'($urandom_range(0, 255));
            y = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255));
            run_op(o, x, y, 0, 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, multi-cycle successor to the combinational ALU. It executes ADD, SUB, AND, OR, XOR, logical shifts and an iterative shift-add multiply on W-bit operands behind a start/busy/done handshake, and holds the result and N/Z/C/V flags in registers until the next operation completes. It sits between the operand/control source (switches or a controller FSM) and the result consumers (seven-segment decoder, status LEDs).

## Interface
- W, default 8: operand and result width, ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  W  operand A, captured on accepted start.
- b  in  W  operand B / shift amount, captured on accepted start.
- op  in  3  opcode, captured on accepted start.
- result  out  W  registered result.
- n_flag, z_flag, c_flag, v_flag  out  1 each  registered status flags.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse: result/flags just updated.

## Operation
- Opcodes: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SHL=101, SHR=110, MUL=111. All codes are defined.
- ADD: result = a+b mod 2^W. C = carry out. V = a[W-1]==b[W-1] && result[W-1]!=a[W-1].
- SUB: result = a−b mod 2^W. C = 1 when a ≥ b unsigned, i.e. no borrow. V = (a[W-1]^b[W-1]) & (a[W-1]^result[W-1]).
- AND/OR/XOR: bitwise. C=V=0.
- SHL/SHR: logical shift of a by unsigned b. Shift by 0: result=a, C=0. Shift by 1..W-1: C = last bit shifted out. Shift by ≥W: result=0, C=0. V=0.
- MUL: unsigned. The 2W-bit product is formed by W shift-add iterations. result = low W bits. C=V=1 when the high W bits are nonzero.
- All ops: N = result[W-1]; Z = (result==0).
- FSM states: IDLE, MUL.
  - IDLE, start=1, op≠MUL → evaluate, register result and flags, pulse done, stay in IDLE.
  - IDLE, start=1, op=MUL → capture a, b; clear accumulator and counter; go to MUL.
  - MUL → one iteration per cycle. After iteration W, register result and flags, pulse done, return to IDLE.
- start while busy=1 is ignored: no capture, no queueing.
- result and flags hold their last value between operations; only a done cycle changes them.

## Timing
- Reset (rst=1 at an edge): state=IDLE; result=0; all flags=0; busy=0; done=0; counter and accumulator cleared.
- Reset mid-MUL aborts the operation with no done pulse. A start in the first cycle after rst deasserts is accepted.
- Single-cycle ops: start accepted at edge k → result, flags and done=1 visible in cycle k+1. Latency 1. busy stays 0.
- MUL: start accepted at edge k → busy=1 in cycles k+1..k+W. In cycle k+W+1, done=1, busy=0 and result is valid. Latency W+1.
- Back-to-back: a start during a done cycle (state IDLE) is accepted. Single-cycle ops therefore sustain one op per cycle.
- done and busy are never high together.
- Inputs a, b and op may change freely while busy=1.

## Structure
- Package alu_seq_pkg holds:
  - opcode enum alu_op_e (3-bit, values above);
  - state enum alu_state_e {IDLE, MUL};
  - flag struct {n, z, c, v}.
- Sub-module alu_seq_mul: iterative W-cycle shift-add unsigned multiplier with load/step inputs and a 2W-bit product output. It is controlled by the alu_seq FSM.
- The counter is $clog2(W)+1 bits wide.
- Single-cycle datapath is combinational logic feeding the result/flag registers.

## Test plan (W=8)
- ADD a=0x7F, b=0x01 → cycle 1: result=0x80, N=1, Z=0, C=0, V=1, done=1.
- SUB a=0x05, b=0x05 → result=0x00, Z=1, C=1, V=0. SUB a=0x03, b=0x05 → result=0xFE, N=1, C=0.
- SHL a=0x81, b=1 → result=0x02, C=1. SHR a=0x81, b=8 → result=0x00, Z=1, C=0.
- MUL a=15, b=17 → busy cycles 1–8, done cycle 9, result=0xFF, C=V=0, N=1. MUL a=16, b=16 → result=0x00, Z=1, C=V=1.
- Start ADD during MUL busy (cycle 3) → ignored; MUL result unchanged, single done at cycle 9.
- rst=1 at cycle 4 of MUL → cycle 5: result=0, flags=0, busy=0, no done. Next start ADD 2+3 → result=0x05 one cycle later.
